// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity encodings, FSM states, line levels and bit-timing helpers.
// ST_BREAK exists only when UART_FRAME_TX_BREAK_EN is defined.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
`ifdef UART_FRAME_TX_BREAK_EN
        , ST_BREAK
`endif
    } tx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    function automatic int cnt_width(input int cpb);
        return cpb > 1 ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if: host word handshake plus serial line and status of the UART frame transmitter.
interface uart_frame_tx_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_valid;
    logic                         tx_ready;
    logic                         uart_tx;
    logic                         busy;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, uart_tx, busy, fifo_level
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, uart_tx, busy, fifo_level
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy level; full blocks pushes even with a same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = level_q == (AW+1)'(DEPTH);
    assign empty_o = level_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push && !rst)
            mem_q[wr_q] <= wdata_i;
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(do_pop);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: FIFO-buffered UART frame serialiser with configurable width, bit order, parity and stop bits.
// Optional line break generator (send_break port, BREAK state) enabled by UART_FRAME_TX_BREAK_EN.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUDRATE        = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int MSB_FIRST       = 1,
    parameter int FIFO_DEPTH      = 16
) (
    input logic clk,
    input logic rst,
`ifdef UART_FRAME_TX_BREAK_EN
    input logic send_break,
`endif
    uart_frame_tx_if.slave bus
);
    localparam int CPB = clks_per_bit(CLOCK_FREQUENCY, BAUDRATE);
    localparam int CW  = cnt_width(CPB);
    localparam logic [CW-1:0] TICK_MAX  = CW'(CPB - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_FRAME_TX_BREAK_EN
    localparam logic [3:0]    BREAK_LOW = 4'(DATA_BITS + 4);
`endif

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, fifo_rdata;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 fifo_full, fifo_empty, push, pop, tick;

    assign bus.tx_ready = !fifo_full && !rst;
    assign push         = bus.tx_valid && bus.tx_ready;
    assign tick         = cnt_q == TICK_MAX;
    assign bus.uart_tx  = tx_q;
    assign bus.busy     = busy_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.tx_data),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (bus.fifo_level)
    );

    // tx_d is the level for the current state; registering it keeps the line glitch-free
    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == ST_IDLE || tick) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        pop     = 1'b0;
        tx_d    = UART_IDLE;
        case (state_q)
            ST_IDLE: begin
                bit_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
`ifdef UART_FRAME_TX_BREAK_EN
                else if (send_break)
                    state_d = ST_BREAK;
`endif
            end
            ST_START: begin
                tx_d = UART_START;
                if (tick)
                    state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_d = MSB_FIRST != 0 ? sh_q[DATA_BITS-1] : sh_q[0];
                if (tick) begin
                    sh_d  = MSB_FIRST != 0 ? sh_q << 1 : sh_q >> 1;
                    bit_d = bit_q == LAST_DATA ? '0 : bit_q + 1'b1;
                    if (bit_q == LAST_DATA)
                        state_d = PARITY != PARITY_NONE ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                tx_d = par_q;
                if (tick)
                    state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    bit_d = bit_q == LAST_STOP ? '0 : bit_q + 1'b1;
                    if (bit_q == LAST_STOP) begin
                        pop     = !fifo_empty;
                        state_d = fifo_empty ? ST_IDLE : ST_START;
                    end
                end
            end
`ifdef UART_FRAME_TX_BREAK_EN
            ST_BREAK: begin
                tx_d = bit_q == BREAK_LOW ? UART_IDLE : UART_START;
                if (tick) begin
                    bit_d = bit_q == BREAK_LOW ? '0 : bit_q + 1'b1;
                    if (bit_q == BREAK_LOW)
                        state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        if (pop) begin
            sh_d  = fifo_rdata;
            par_d = (^fifo_rdata) ^ (PARITY == PARITY_ODD);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= UART_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= state_q != ST_IDLE || !fifo_empty;
        end
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: table-driven frame checks on three uart_frame_tx configurations plus burst, full-FIFO and reset sequences.
module tb_uart_frame_tx;
    localparam int CPB = 4;

    typedef struct {
        int          u;
        logic [7:0]  d;
        int          nb;
        logic [63:0] f;
    } vec_t;

    logic clk, rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   n;
    logic [2:0] hl [8192];
    logic [2:0] hb [8192];
    logic [7:0] words [32];
    vec_t tv [9];

    uart_frame_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b0 ();
    uart_frame_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  b1 ();
    uart_frame_tx_if #(.DATA_BITS(8), .FIFO_DEPTH(2))  b2 ();

    uart_frame_tx #(.CLOCK_FREQUENCY(40), .BAUDRATE(10)) u0 (
        .clk(clk), .rst(rst),
`ifdef UART_FRAME_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .bus(b0.slave));
    uart_frame_tx #(.CLOCK_FREQUENCY(40), .BAUDRATE(10), .PARITY(2), .STOP_BITS(2),
                    .MSB_FIRST(0), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst),
`ifdef UART_FRAME_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .bus(b1.slave));
    uart_frame_tx #(.CLOCK_FREQUENCY(40), .BAUDRATE(10), .PARITY(1), .FIFO_DEPTH(2)) u2 (
        .clk(clk), .rst(rst),
`ifdef UART_FRAME_TX_BREAK_EN
        .send_break(1'b0),
`endif
        .bus(b2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 8192) begin
            hl[cyc] = {b2.uart_tx, b1.uart_tx, b0.uart_tx};
            hb[cyc] = {b2.busy, b1.busy, b0.busy};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int u, input logic v, input logic [7:0] d);
        case (u)
            0: begin b0.tx_valid = v; b0.tx_data = d; end
            1: begin b1.tx_valid = v; b1.tx_data = d; end
            default: begin b2.tx_valid = v; b2.tx_data = d; end
        endcase
    endtask

    // words[0..cnt-1] on consecutive cycles; n is the edge that accepts words[0]
    task automatic send(input int u, input int cnt, output int first);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            if (i == 0) first = cyc + 1;
            drive(u, 1'b1, words[i]);
        end
        @(negedge clk);
        drive(u, 1'b0, 8'h00);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_frame(input string nm, input int u, input int n0, input int nb,
                               input logic [63:0] exp, input bit last);
        int st, bad;
        logic [63:0] cap;
        st = -1;
        for (int c = n0; c < n0 + 10 && st < 0; c++)
            if (hl[c][u] === 1'b0) st = c;
        check({nm, " start latency"}, 64'(st - n0), 64'd2);
        if (st < 0) st = n0 + 2;
        bad = 0;
        cap = '0;
        for (int j = 0; j < nb * CPB; j++) begin
            if (hl[st + j][u] !== exp[nb - 1 - j / CPB]) bad++;
            if (j % CPB == CPB / 2) cap = {cap[62:0], hl[st + j][u]};
        end
        check({nm, " bits"}, cap, exp);
        check({nm, " bit timing errors"}, 64'(bad), 64'd0);
        if (last)
            check({nm, " busy at/after last stop"},
                  {62'd0, hb[st + nb * CPB - 1][u], hb[st + nb * CPB][u]}, 64'b10);
    endtask

    initial begin
        tv[0] = '{0, 8'h10, 10, 64'(10'b0_00010000_1)};
        tv[1] = '{0, 8'hA5, 10, 64'(10'b0_10100101_1)};
        tv[2] = '{0, 8'h01, 10, 64'(10'b0_00000001_1)};
        tv[3] = '{1, 8'h01, 12, 64'(12'b0_10000000_1_11)};
        tv[4] = '{1, 8'h11, 12, 64'(12'b0_10001000_0_11)};
        tv[5] = '{1, 8'hC3, 12, 64'(12'b0_11000011_0_11)};
        tv[6] = '{2, 8'h11, 11, 64'(11'b0_00010001_1_1)};
        tv[7] = '{2, 8'h07, 11, 64'(11'b0_00000111_0_1)};
        tv[8] = '{2, 8'h80, 11, 64'(11'b0_10000000_0_1)};

        rst = 1'b1;
        drive(0, 1'b1, 8'h55);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("reset uart_tx", 64'(b0.uart_tx), 64'd1);
        check("reset busy", 64'(b0.busy), 64'd0);
        check("reset fifo_level", 64'(b0.fifo_level), 64'd0);
        check("reset tx_ready", 64'(b0.tx_ready), 64'd0);
        rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        @(negedge clk);
        check("post-reset fifo_level", 64'(b0.fifo_level), 64'd0);
        check("post-reset tx_ready", 64'(b0.tx_ready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            words[0] = tv[i].d;
            send(tv[i].u, 1, n);
            run_to(n + 2 + tv[i].nb * CPB + 4);
            check_frame($sformatf("vec%0d", i), tv[i].u, n, tv[i].nb, tv[i].f, 1'b1);
        end

        words[0] = 8'h10; words[1] = 8'h01; words[2] = 8'h11; words[3] = 8'h30;
        send(0, 4, n);
        check("burst fifo_level", 64'(b0.fifo_level), 64'd3);
        run_to(n + 2 + 40 * CPB + 4);
        for (int k = 0; k < 4; k++)
            check_frame($sformatf("burst%0d", k), 0, n + 10 * CPB * k, 10,
                        64'({1'b0, words[k], 1'b1}), k == 3);

        for (int i = 0; i < 20; i++) words[i] = 8'h40 + 8'(i);
        send(0, 20, n);
        check("full fifo_level", 64'(b0.fifo_level), 64'd16);
        check("full tx_ready", 64'(b0.tx_ready), 64'd0);
        run_to(n + 2 + 17 * 10 * CPB + 4);
        for (int k = 0; k < 17; k++)
            check_frame($sformatf("full%0d", k), 0, n + 10 * CPB * k, 10,
                        64'({1'b0, words[k], 1'b1}), k == 16);
        check("full drained fifo_level", 64'(b0.fifo_level), 64'd0);

        words[0] = 8'h00; words[1] = 8'h01; words[2] = 8'h02; words[3] = 8'h03;
        send(0, 4, n);
        run_to(n + 8);
        check("midreset line low in data", 64'(b0.uart_tx), 64'd0);
        rst = 1'b1;
        drive(0, 1'b1, 8'hAA);
        @(negedge clk);
        check("midreset uart_tx", 64'(b0.uart_tx), 64'd1);
        check("midreset busy", 64'(b0.busy), 64'd0);
        check("midreset fifo_level", 64'(b0.fifo_level), 64'd0);
        check("midreset tx_ready", 64'(b0.tx_ready), 64'd0);
        rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        @(negedge clk);
        check("midreset push ignored", 64'(b0.fifo_level), 64'd0);
        words[0] = 8'h30;
        send(0, 1, n);
        run_to(n + 2 + 10 * CPB + 4);
        check_frame("after reset", 0, n, 10, 64'(10'b0_00110000_1), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised, FIFO-buffered UART frame transmitter. It serialises host words onto a single TX line with configurable data width, bit order, parity and stop bits. It is the synthesizable, generalised successor to the hand-sequenced UART frame stimulus used on the CAC UART receive path. It serves both as a CAC UART TX engine in the top level and as a reusable frame driver in benches.

Parameters:
- CLOCK_FREQUENCY, 100_000_000: clk frequency in Hz.
- BAUDRATE, 115200: line rate in bit/s.
- DATA_BITS, 8: payload bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- MSB_FIRST, 1: 1 = bit DATA_BITS-1 sent first; 0 = LSB first.
- FIFO_DEPTH, 16: word buffer depth, a power of 2 and at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-high.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  FIFO can accept a word.
- uart_tx  out  1  serial line, idle high.
- busy  out  1  a frame is being shifted, or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently held.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst).
  - uart_tx=1, busy=0, fifo_level=0, tx_ready=0 while rst=1.
  - FIFO is flushed; FSM returns to IDLE.
- Bit timing: CLKS_PER_BIT = CLOCK_FREQUENCY/BAUDRATE, integer truncation. Every line bit lasts exactly CLKS_PER_BIT cycles.
- Handshake: a word is accepted on any clk edge where tx_valid && tx_ready.
  - tx_ready = !full, registered-state based.
  - When the FIFO is full, a same-cycle pop does not enable a push.
- FSM states and transitions:
  - IDLE: when FIFO is not empty, pop one word into the shift register, then go to START.
  - START: drive 0 for one bit-time.
  - DATA: shift DATA_BITS bits in MSB_FIRST order.
  - PARITY: present only if PARITY != 0. Sends XOR of the data bits for even parity, or its inverse for odd parity.
  - STOP: drive 1 for STOP_BITS bit-times. At the end, pop the next word if FIFO is not empty (straight to START, no idle gap); otherwise go to IDLE.
- Latency: a word accepted at cycle N with the FIFO empty and FSM in IDLE produces uart_tx=0 (start bit) at cycle N+2.
- uart_tx is registered and glitch-free.
- fifo_level tracks push/pop exactly. Simultaneous push and pop leaves it unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_level never exceeds FIFO_DEPTH.
- Reset mid-frame: uart_tx=1 from the cycle after rst is sampled; the partial frame is discarded.
- tx_data and tx_valid are ignored while rst=1.

Optional Feature:
- Macro: UART_FRAME_TX_BREAK_EN.
- Defined:
  - Adds input port send_break (1 bit).
  - If send_break is sampled high while in IDLE, the FSM enters BREAK: uart_tx=0 for (DATA_BITS+4)*CLKS_PER_BIT cycles, then 1 for one bit-time, then IDLE.
  - FIFO pushes are still accepted during BREAK; no pops occur.
  - send_break is ignored outside IDLE.
  - busy=1 during BREAK.
- Undefined: no send_break port and no BREAK state. Logic is otherwise identical.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings PARITY_NONE/ODD/EVEN;
  - FSM state encodings;
  - a constant function computing CLKS_PER_BIT and the counter width;
  - line levels UART_IDLE=1 and UART_START=0.
- One natural sub-module: sync_fifo (width DATA_BITS, depth FIFO_DEPTH, level output). It is reused by the future RX path.

Test Plan:
- 8N1, MSB_FIRST=1, push 0x10 → uart_tx sequence 0,0,0,0,1,0,0,0,0,1, each held CLKS_PER_BIT cycles; start bit at N+2.
- PARITY=2, push 0x11 → parity bit 0. PARITY=1, same word → parity bit 1. Frame is 11 bit-times.
- Burst 0x10, 0x01, 0x11, 0x30 on consecutive cycles → four frames back-to-back with no idle gap, 40 bit-times total; busy falls 1 cycle after the last stop bit.
- FIFO_DEPTH=16: hold tx_valid for 20 cycles during the first frame → fifo_level reaches 16 and tx_ready=0; excess words are not accepted and no word is lost or duplicated.
- STOP_BITS=2, MSB_FIRST=0, push 0x01 → first data bit 1; stop high for 2*CLKS_PER_BIT cycles.
- Assert rst in DATA state with 3 words queued → next cycle uart_tx=1, busy=0, fifo_level=0; after release, push 0x30 → a clean frame is sent.
